semi_auto_nav: RTL and testbench

Parametrised semi-automatic driving controller for the car simulation, clocked from the 500 Hz control tick. It accepts one-shot direction commands from the operator, runs the car down a corridor until the detectors report a junction or wall, and either stops or (in auto mode) picks the next direction itself. Turns are requested from the external turning block through a trigger/busy handshake, with an optional turn-timeout fault. It sits between the manual-command decoder and the turning/motor blocks.

---
 rtl/semi_auto_nav.sv | 254 +++++++++++++++++++++++++
 tb/tb_semi_auto_nav.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/semi_auto_nav.sv
// rtl/semi_auto_nav.sv - semi-automatic corridor driving controller with turn handshake
//
// Purpose:
//   Takes one-shot operator direction commands and drives the car down a corridor
//   until the detectors report a junction or wall. In semi-auto mode the car then
//   stops, or takes the only open side turn. In auto mode it follows the right-hand
//   rule. Turns are requested from the turning block with a fixed-length trigger
//   pulse, and the turn is considered done after a busy pulse has been seen and
//   has ended.
//
// Optional feature macro: SEMI_AUTO_TIMEOUT_EN
//   When defined, TURNING is bounded by TURN_TIMEOUT_CYC and overruns go to FAULT.
//   When undefined, TURNING waits indefinitely and fault is tied low.
//
// Ports:
//   clk              control clock (500 Hz tick); all registers update on its falling edge
//   rst              synchronous active-high reset, has priority over enable
//   enable           low forces WAITING on the next edge (junction_cnt is kept)
//   mode             0 = semi-auto (stop at junctions), 1 = auto (right-hand rule)
//   move_forward     operator command: go forward
//   move_left        operator command: turn left
//   move_right       operator command: turn right
//   move_backward    operator command: turn around
//   detector[3:0]    obstacle flags, 1 = blocked: [3] front, [2] back, [1] left, [0] right
//   is_turning       busy flag from the turning block
//   out_move_forward drive-forward request to the motor block
//   trig_left        left-turn trigger
//   trig_right       right-turn trigger
//   trig_back        turn-around trigger
//   out_state[3:0]   current state code
//   junction_cnt     junctions passed, saturating at all-ones
//   fault            turn timeout indication
module semi_auto_nav #(
  parameter int TURN_TRIGGER_CYC = 100,
  parameter int MOVE_END_CYC     = 50,
  parameter int TURN_TIMEOUT_CYC = 1500,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic             move_forward,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             move_backward,
  input  logic [3:0]       detector,
  input  logic             is_turning,
  output logic             out_move_forward,
  output logic             trig_left,
  output logic             trig_right,
  output logic             trig_back,
  output logic [3:0]       out_state,
  output logic [CNT_W-1:0] junction_cnt,
  output logic             fault
);

  // The enum values are the externally visible state codes.
  typedef enum logic [3:0] {
    S_MOVING_END = 4'b0000,
    S_WAITING    = 4'b0001,
    S_TRIG_L     = 4'b0010,
    S_TRIG_R     = 4'b0011,
    S_TRIG_B     = 4'b0100,
    S_TURNING    = 4'b0101,
    S_DIR_MOVING = 4'b0110,
    S_MOVING     = 4'b0111,
    S_FAULT      = 4'b1000
  } state_e;

  localparam logic [31:0] TrigLast    = 32'(TURN_TRIGGER_CYC - 1);
  localparam logic [31:0] EndLast     = 32'(MOVE_END_CYC - 1);
  localparam logic [31:0] TimeoutLast = 32'(TURN_TIMEOUT_CYC - 1);

`ifdef SEMI_AUTO_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  // Detector aliases, 1 = blocked.
  logic det_front, det_back, det_left, det_right;
  assign det_front = detector[3];
  assign det_back  = detector[2];
  assign det_left  = detector[1];
  assign det_right = detector[0];

  // Commands are only honoured when exactly one is asserted.
  logic [3:0] cmd_vec;
  logic       cmd_single;
  assign cmd_vec    = {move_forward, move_left, move_right, move_backward};
  assign cmd_single = $onehot(cmd_vec);

  state_e           state_q, state_d;
  logic [31:0]      trig_cnt_q, trig_cnt_d;
  logic [31:0]      end_cnt_q, end_cnt_d;
  logic [31:0]      turn_cnt_q, turn_cnt_d;
  logic             seen_busy_q, seen_busy_d;
  logic [CNT_W-1:0] junction_cnt_q, junction_cnt_d;

  logic in_trig;
  assign in_trig = (state_q == S_TRIG_L) || (state_q == S_TRIG_R) || (state_q == S_TRIG_B);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_WAITING;
    end else begin
      case (state_q)
        S_WAITING: begin
          if (cmd_single) begin
            if (move_forward && !det_front) begin
              state_d = S_DIR_MOVING;
            end else if (move_left && !det_left) begin
              state_d = S_TRIG_L;
            end else if (move_right && !det_right) begin
              state_d = S_TRIG_R;
            end else if (move_backward && !det_back) begin
              state_d = S_TRIG_B;
            end
          end
        end

        S_TRIG_L, S_TRIG_R, S_TRIG_B: begin
          if (trig_cnt_q == TrigLast) begin
            state_d = S_TURNING;
          end
        end

        S_TURNING: begin
          // The turn is finished only once busy has been seen and then dropped.
          // A normal exit takes precedence over a timeout on the same edge.
          if (seen_busy_q && !is_turning) begin
            state_d = S_DIR_MOVING;
          end else if (TimeoutEn && (turn_cnt_q == TimeoutLast)) begin
            state_d = S_FAULT;
          end
        end

        S_DIR_MOVING: begin
          // Wait until the car is properly inside a corridor (walls both sides,
          // front and back open) before watching for junctions.
          if (detector == 4'b0011) begin
            state_d = S_MOVING;
          end
        end

        S_MOVING: begin
          if (!det_left || !det_right || det_front) begin
            state_d = S_MOVING_END;
          end
        end

        S_MOVING_END: begin
          // The detector is only consulted on the final cycle, once the car has
          // rolled into the junction.
          if (end_cnt_q == EndLast) begin
            if (!mode) begin
              case (detector)
                4'b1011: state_d = S_TRIG_B;
                4'b1001: state_d = S_TRIG_L;
                4'b1010: state_d = S_TRIG_R;
                default: state_d = S_WAITING;
              endcase
            end else begin
              if (!det_right) begin
                state_d = S_TRIG_R;
              end else if (!det_front) begin
                state_d = S_DIR_MOVING;
              end else if (!det_left) begin
                state_d = S_TRIG_L;
              end else begin
                state_d = S_TRIG_B;
              end
            end
          end
        end

        S_FAULT: begin
          state_d = S_FAULT;
        end

        default: begin
          state_d = S_WAITING;
        end
      endcase
    end
  end

  // Timers and flags. Each timer only advances while its state is held, so it
  // is zero on every entry into that state.
  always_comb begin
    trig_cnt_d     = '0;
    end_cnt_d      = '0;
    turn_cnt_d     = '0;
    seen_busy_d    = 1'b0;
    junction_cnt_d = junction_cnt_q;

    if (in_trig && (state_d == state_q)) begin
      trig_cnt_d = trig_cnt_q + 32'd1;
    end

    if ((state_q == S_MOVING_END) && (state_d == S_MOVING_END)) begin
      end_cnt_d = end_cnt_q + 32'd1;
    end

    if ((state_q == S_TURNING) && (state_d == S_TURNING)) begin
      seen_busy_d = seen_busy_q | is_turning;
      if (TimeoutEn) begin
        turn_cnt_d = turn_cnt_q + 32'd1;
      end
    end

    // A junction is counted on the edge that leaves MOVING.
    if ((state_q == S_MOVING) && (state_d == S_MOVING_END) && (junction_cnt_q != '1)) begin
      junction_cnt_d = junction_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q        <= S_WAITING;
      trig_cnt_q     <= '0;
      end_cnt_q      <= '0;
      turn_cnt_q     <= '0;
      seen_busy_q    <= 1'b0;
      junction_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      trig_cnt_q     <= trig_cnt_d;
      end_cnt_q      <= end_cnt_d;
      turn_cnt_q     <= turn_cnt_d;
      seen_busy_q    <= seen_busy_d;
      junction_cnt_q <= junction_cnt_d;
    end
  end

  // Moore outputs.
  assign out_state        = state_q;
  assign out_move_forward = (state_q == S_DIR_MOVING) || (state_q == S_MOVING) ||
                            (state_q == S_MOVING_END);
  assign trig_left        = (state_q == S_TRIG_L);
  assign trig_right       = (state_q == S_TRIG_R);
  assign trig_back        = (state_q == S_TRIG_B);
  assign junction_cnt     = junction_cnt_q;

`ifdef SEMI_AUTO_TIMEOUT_EN
  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_semi_auto_nav.sv
// tb/tb_semi_auto_nav.sv - scoreboard bench for semi_auto_nav
module tb_semi_auto_nav;

  localparam int TT = 5;   // trigger cycles
  localparam int ME = 3;   // move-end cycles
  localparam int TO = 25;  // turn timeout cycles
  localparam int CW = 3;   // junction counter width

`ifdef SEMI_AUTO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // State codes as listed for out_state.
  localparam logic [3:0] C_WAIT  = 4'b0001;
  localparam logic [3:0] C_TL    = 4'b0010;
  localparam logic [3:0] C_TR    = 4'b0011;
  localparam logic [3:0] C_TB    = 4'b0100;
  localparam logic [3:0] C_TURN  = 4'b0101;
  localparam logic [3:0] C_DIR   = 4'b0110;
  localparam logic [3:0] C_MOV   = 4'b0111;
  localparam logic [3:0] C_END   = 4'b0000;
  localparam logic [3:0] C_FAULT = 4'b1000;

  logic          clk = 1'b0;
  logic          rst, enable, mode;
  logic          move_forward, move_left, move_right, move_backward;
  logic [3:0]    detector;
  logic          is_turning;
  logic          out_move_forward, trig_left, trig_right, trig_back, fault;
  logic [3:0]    out_state;
  logic [CW-1:0] junction_cnt;

  always #5 clk = ~clk;

  semi_auto_nav #(
    .TURN_TRIGGER_CYC(TT),
    .MOVE_END_CYC(ME),
    .TURN_TIMEOUT_CYC(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .move_forward(move_forward), .move_left(move_left),
    .move_right(move_right), .move_backward(move_backward),
    .detector(detector), .is_turning(is_turning),
    .out_move_forward(out_move_forward), .trig_left(trig_left),
    .trig_right(trig_right), .trig_back(trig_back),
    .out_state(out_state), .junction_cnt(junction_cnt), .fault(fault)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          fwd, tl, tr, tb, flt;
    logic [CW-1:0] jc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: phase plus countdown of cycles left in the phase.
  logic [3:0] m_st   = C_WAIT;
  int         m_left = 0;
  bit         m_seen = 1'b0;
  int         m_jc   = 0;

  function automatic void model_step(input bit r, input bit en, input bit md,
                                     input logic [3:0] cmd, input logic [3:0] det,
                                     input bit busy);
    if (r) begin
      m_st = C_WAIT; m_left = 0; m_seen = 1'b0; m_jc = 0;
    end else if (!en) begin
      m_st = C_WAIT;
    end else begin
      case (m_st)
        C_WAIT: if ($countones(cmd) == 1) begin
          if (cmd[3] && !det[3])      m_st = C_DIR;
          else if (cmd[2] && !det[1]) begin m_st = C_TL; m_left = TT; end
          else if (cmd[1] && !det[0]) begin m_st = C_TR; m_left = TT; end
          else if (cmd[0] && !det[2]) begin m_st = C_TB; m_left = TT; end
        end
        C_TL, C_TR, C_TB: begin
          m_left--;
          if (m_left == 0) begin m_st = C_TURN; m_seen = 1'b0; m_left = TO; end
        end
        C_TURN: begin
          if (m_seen && !busy) m_st = C_DIR;
          else begin
            m_seen = m_seen | busy;
            m_left--;
            if (TO_EN && m_left == 0) m_st = C_FAULT;
          end
        end
        C_DIR: if (det == 4'b0011) m_st = C_MOV;
        C_MOV: if (!det[1] || !det[0] || det[3]) begin
          m_st = C_END; m_left = ME;
          if (m_jc < (1 << CW) - 1) m_jc++;
        end
        C_END: begin
          m_left--;
          if (m_left == 0) begin
            if (!md) begin
              if (det == 4'b1011)      begin m_st = C_TB; m_left = TT; end
              else if (det == 4'b1001) begin m_st = C_TL; m_left = TT; end
              else if (det == 4'b1010) begin m_st = C_TR; m_left = TT; end
              else m_st = C_WAIT;
            end else begin
              if (!det[0])      begin m_st = C_TR; m_left = TT; end
              else if (!det[3]) m_st = C_DIR;
              else if (!det[1]) begin m_st = C_TL; m_left = TT; end
              else              begin m_st = C_TB; m_left = TT; end
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st  = m_st;
    e.fwd = (m_st == C_DIR) || (m_st == C_MOV) || (m_st == C_END);
    e.tl  = (m_st == C_TL);
    e.tr  = (m_st == C_TR);
    e.tb  = (m_st == C_TB);
    e.flt = (m_st == C_FAULT);
    e.jc  = CW'(m_jc);
    return e;
  endfunction

  // cmd bits: [3] forward, [2] left, [1] right, [0] backward
  task automatic drive(input bit r, input bit en, input bit md,
                       input logic [3:0] cmd, input logic [3:0] det, input bit busy);
    @(posedge clk);
    #1;
    rst = r; enable = en; mode = md;
    move_forward = cmd[3]; move_left = cmd[2]; move_right = cmd[1]; move_backward = cmd[0];
    detector = det; is_turning = busy;
    model_step(r, en, md, cmd, det, busy);
    sb.push_back(model_out());
  endtask

  // Monitor: DUT updates on the falling edge, so outputs are stable at the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (out_state !== e.st || out_move_forward !== e.fwd || trig_left !== e.tl ||
            trig_right !== e.tr || trig_back !== e.tb || fault !== e.flt ||
            junction_cnt !== e.jc) begin
          n_err++;
          $display("FAIL outputs vec %0d: got st=%b fwd=%b tl=%b tr=%b tb=%b flt=%b jc=%0d, expected st=%b fwd=%b tl=%b tr=%b tb=%b flt=%b jc=%0d",
                   n_vec, out_state, out_move_forward, trig_left, trig_right, trig_back,
                   fault, junction_cnt, e.st, e.fwd, e.tl, e.tr, e.tb, e.flt, e.jc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] cmd, det;
    bit busy_r;
    int drain;
    rst = 1'b1; enable = 1'b1; mode = 1'b0;
    move_forward = 1'b0; move_left = 1'b0; move_right = 1'b0; move_backward = 1'b0;
    detector = 4'b0000; is_turning = 1'b0;

    // Reset and forward run.
    drive(1, 1, 0, 4'b0000, 4'b0000, 0);
    drive(1, 1, 0, 4'b0000, 4'b0000, 0);
    drive(0, 1, 0, 4'b1000, 4'b0000, 0);
    drive(0, 1, 0, 4'b0000, 4'b0011, 0);
    // Junction in semi mode, left opening, detector noise ignored until decision.
    drive(0, 1, 0, 4'b0000, 4'b1001, 0);
    for (int i = 0; i < ME - 1; i++) drive(0, 1, 0, 4'b0000, 4'b0110, 0);
    drive(0, 1, 0, 4'b0000, 4'b1001, 0);
    // Trigger phase with a busy blip that must be ignored.
    for (int i = 0; i < TT; i++) drive(0, 1, 0, 4'b0000, 4'b0011, i == 1);
    // Handshake: idle, busy, then release.
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 4'b0000, 4'b0011, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 4'b0000, 4'b0011, 1);
    drive(0, 1, 0, 4'b0000, 4'b0011, 0);
    // Auto mode: right opening at decision -> right trigger.
    drive(0, 1, 1, 4'b0000, 4'b0011, 0);
    drive(0, 1, 1, 4'b0000, 4'b0010, 0);
    for (int i = 0; i < ME - 1; i++) drive(0, 1, 1, 4'b0000, 4'b1111, 0);
    drive(0, 1, 1, 4'b0000, 4'b0010, 0);
    for (int i = 0; i < TT; i++) drive(0, 1, 1, 4'b0000, 4'b0011, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 4'b0000, 4'b0011, 1);
    drive(0, 1, 1, 4'b0000, 4'b0011, 0);
    // Auto mode: left opening only, front free -> straight on.
    drive(0, 1, 1, 4'b0000, 4'b0011, 0);
    drive(0, 1, 1, 4'b0000, 4'b0001, 0);
    for (int i = 0; i < ME - 1; i++) drive(0, 1, 1, 4'b0000, 4'b0000, 0);
    drive(0, 1, 1, 4'b0000, 4'b0001, 0);
    // Enable low, then blocked and ambiguous commands.
    drive(0, 0, 0, 4'b0000, 4'b0011, 0);
    drive(0, 1, 0, 4'b0100, 4'b0010, 0);
    drive(0, 1, 0, 4'b0110, 4'b0000, 0);
    drive(0, 1, 0, 4'b0001, 4'b0100, 0);
    drive(0, 1, 0, 4'b1000, 4'b1000, 0);
    drive(0, 1, 0, 4'b1111, 4'b0000, 0);
    // Turn-around with busy stuck high: fault when the timeout is built in.
    drive(0, 1, 0, 4'b0001, 4'b0000, 0);
    for (int i = 0; i < TT; i++) drive(0, 1, 0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < TO + 3; i++) drive(0, 1, 0, 4'b0000, 4'b0000, 1);
    drive(0, 0, 0, 4'b0000, 4'b0000, 1);
    drive(0, 1, 0, 4'b0000, 4'b0000, 0);
    // Drive the junction counter into saturation.
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 0, 4'b1000, 4'b0000, 0);
      drive(0, 1, 0, 4'b0000, 4'b0011, 0);
      for (int i = 0; i < ME + 1; i++) drive(0, 1, 0, 4'b0000, 4'b0000, 0);
    end
    // Randomized phase.
    busy_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 7) cmd = 4'b0000;
      else if ($urandom_range(0, 4) != 0) cmd = 4'(1 << $urandom_range(0, 3));
      else cmd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) det = 4'b0011;
      else det = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) busy_r = ~busy_r;
      drive($urandom_range(0, 599) == 0, $urandom_range(0, 199) != 0,
            1'($urandom_range(0, 1)), cmd, det, busy_r);
    end
    // Let the monitor consume the last expectations.
    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
